// File: rtl/dmem_boot_loader.sv
// Boot-time sequencer: holds the RV32I top in reset while streaming NUM_WORDS
// words into data memory through its external write port, then releases it.
module dmem_boot_loader #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned NUM_WORDS     = 64,
  parameter int unsigned RELEASE_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam logic [15:0] LAST_IDX   = 16'(NUM_WORDS - 1);
  localparam logic [31:0] DELAY_INIT = 32'(RELEASE_DELAY);
  localparam logic [1:0]  START_DEST = (NUM_WORDS == 0) ? ST_HOLD : ST_LOAD;

  logic [1:0]  state_q, state_d;
  logic [15:0] word_count_q, word_count_d;
  logic [31:0] delay_q, delay_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] data_adr_q, data_adr_d;
  logic        accept;

  assign accept = in_valid && (state_q == ST_LOAD);

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    delay_d      = delay_q;
    mem_write_d  = 1'b0;
    write_data_d = write_data_q;
    data_adr_d   = data_adr_q;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          state_d      = START_DEST;
          word_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_write_d  = 1'b1;
          write_data_d = in_data;
          data_adr_d   = BASE_ADDR + {14'b0, word_count_q, 2'b00};
          if (word_count_q != '1) begin
            word_count_d = word_count_q + 16'd1;
          end
          if (word_count_q == LAST_IDX) begin
            state_d = ST_HOLD;
          end
        end
      end
      default: begin
        delay_d = delay_q - 32'd1;
        if (delay_q <= 32'd1) begin
          state_d = ST_RUN;
        end
      end
    endcase

    if (state_d == ST_HOLD && state_q != ST_HOLD) begin
      delay_d = DELAY_INIT;
    end

    // Registered from the next state so the CPU sees reset the cycle after a restart.
    cpu_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      delay_q      <= '0;
      cpu_reset_q  <= 1'b1;
      mem_write_q  <= 1'b0;
      write_data_q <= '0;
      data_adr_q   <= BASE_ADDR;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      delay_q      <= delay_d;
      cpu_reset_q  <= cpu_reset_d;
      mem_write_q  <= mem_write_d;
      write_data_q <= write_data_d;
      data_adr_q   <= data_adr_d;
    end
  end

  assign in_ready      = (state_q == ST_LOAD);
  assign busy          = (state_q == ST_LOAD) || (state_q == ST_HOLD);
  assign done          = (state_q == ST_RUN);
  assign cpu_reset     = cpu_reset_q;
  assign Ext_MemWrite  = mem_write_q;
  assign Ext_WriteData = write_data_q;
  assign Ext_DataAdr   = data_adr_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_dmem_boot_loader.sv
// Scoreboard bench for dmem_boot_loader: three differently parameterised loaders,
// expected writes predicted from the load rules and checked by a negedge monitor.
module tb_dmem_boot_loader;

  logic        clk = 1'b0;
  logic [2:0]  reset_s    = '1;
  logic [2:0]  start_s    = '0;
  logic [2:0]  in_valid_s = '0;
  logic [31:0] in_data_s [3];
  logic [2:0]  in_ready_s, cpu_reset_s, memwr_s, busy_s, done_s;
  logic [31:0] wdata_s [3];
  logic [31:0] adr_s [3];
  logic [15:0] wc_s [3];

  always #5 clk = ~clk;

  dmem_boot_loader #(.BASE_ADDR(32'h0000_0000), .NUM_WORDS(4), .RELEASE_DELAY(4)) u_dut0 (
    .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_data(in_data_s[0]), .in_ready(in_ready_s[0]), .cpu_reset(cpu_reset_s[0]),
    .Ext_MemWrite(memwr_s[0]), .Ext_WriteData(wdata_s[0]), .Ext_DataAdr(adr_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .word_count(wc_s[0]));

  dmem_boot_loader #(.BASE_ADDR(32'h0000_0100), .NUM_WORDS(0), .RELEASE_DELAY(3)) u_dut1 (
    .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_data(in_data_s[1]), .in_ready(in_ready_s[1]), .cpu_reset(cpu_reset_s[1]),
    .Ext_MemWrite(memwr_s[1]), .Ext_WriteData(wdata_s[1]), .Ext_DataAdr(adr_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .word_count(wc_s[1]));

  dmem_boot_loader #(.BASE_ADDR(32'hFFFF_FFF8), .NUM_WORDS(3), .RELEASE_DELAY(2)) u_dut2 (
    .clk(clk), .reset(reset_s[2]), .start(start_s[2]), .in_valid(in_valid_s[2]),
    .in_data(in_data_s[2]), .in_ready(in_ready_s[2]), .cpu_reset(cpu_reset_s[2]),
    .Ext_MemWrite(memwr_s[2]), .Ext_WriteData(wdata_s[2]), .Ext_DataAdr(adr_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .word_count(wc_s[2]));

  typedef struct {
    int          inst;
    logic [31:0] adr;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  writes_seen [3] = '{0, 0, 0};
  int  k_m [3] = '{0, 0, 0};
  bit  loading_m [3] = '{0, 0, 0};

  function automatic logic [31:0] base_of(input int i);
    case (i)
      0: return 32'h0000_0000;
      1: return 32'h0000_0100;
      default: return 32'hFFFF_FFF8;
    endcase
  endfunction

  function automatic int num_of(input int i);
    case (i)
      0: return 4;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int dly_of(input int i);
    case (i)
      0: return 4;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock edge; the reference model updates from the inputs sampled there.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (reset_s[i]) begin
        loading_m[i] = 0;
        k_m[i] = 0;
      end else if (loading_m[i]) begin
        if (in_valid_s[i]) begin
          e.inst = i;
          e.adr  = base_of(i) + (32'(k_m[i]) << 2);
          e.data = in_data_s[i];
          e.due  = cyc;
          exp_q.push_back(e);
          k_m[i]++;
          if (k_m[i] == num_of(i)) loading_m[i] = 0;
        end
      end else if (start_s[i]) begin
        loading_m[i] = (num_of(i) > 0);
        k_m[i] = 0;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    wr_t e;
    for (int i = 0; i < 3; i++) begin
      if (memwr_s[i] === 1'b1) begin
        writes_seen[i]++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write inst=%0d actual adr=%h data=%h required none", i, adr_s[i], wdata_s[i]);
        end else begin
          e = exp_q.pop_front();
          check("wr_inst", i, e.inst);
          check("wr_adr", adr_s[i], e.adr);
          check("wr_data", wdata_s[i], e.data);
          check("wr_cycle", cyc, e.due);
          check("wr_under_cpu_reset", cpu_reset_s[i], 1'b1);
        end
      end
    end
  end

  task automatic check_reset_values(input int i);
    check("rst_cpu_reset", cpu_reset_s[i], 1'b1);
    check("rst_memwrite", memwr_s[i], 1'b0);
    check("rst_wdata", wdata_s[i], 32'h0);
    check("rst_adr", adr_s[i], base_of(i));
    check("rst_word_count", wc_s[i], 32'h0);
    check("rst_in_ready", in_ready_s[i], 1'b0);
    check("rst_busy", busy_s[i], 1'b0);
    check("rst_done", done_s[i], 1'b0);
  endtask

  // mode 0: continuous valid with fixed data; 1: valid pattern 1,0,0; 2: random valid/data/start
  task automatic run_load(input int i, input int mode);
    int n0;
    int c;
    logic [31:0] tbl [4];
    tbl[0] = 32'd11; tbl[1] = 32'd22; tbl[2] = 32'd33; tbl[3] = 32'd44;
    n0 = writes_seen[i];
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
    check("start_cpu_reset", cpu_reset_s[i], 1'b1);
    check("start_done", done_s[i], 1'b0);
    check("start_busy", busy_s[i], 1'b1);
    c = 0;
    while (loading_m[i] && c < 200) begin
      case (mode)
        0: begin
          in_valid_s[i] = 1'b1;
          in_data_s[i]  = tbl[k_m[i] % 4];
        end
        1: begin
          in_valid_s[i] = (c % 3 == 0);
          in_data_s[i]  = $urandom;
        end
        default: begin
          in_valid_s[i] = 1'($urandom_range(0, 1));
          in_data_s[i]  = $urandom;
          start_s[i]    = 1'($urandom_range(0, 1));
        end
      endcase
      tick();
      c++;
      check("in_ready", in_ready_s[i], loading_m[i]);
      check("word_count_live", wc_s[i], k_m[i]);
    end
    in_valid_s[i] = 1'b0;
    start_s[i] = 1'b0;
    if (loading_m[i]) begin
      checks++;
      failures++;
      $display("FAIL load_timeout inst=%0d actual words=%0d required %0d", i, k_m[i], num_of(i));
    end
    for (int j = 0; j < dly_of(i); j++) begin
      check("hold_cpu_reset", cpu_reset_s[i], 1'b1);
      check("hold_done", done_s[i], 1'b0);
      check("hold_busy", busy_s[i], 1'b1);
      tick();
    end
    check("run_cpu_reset", cpu_reset_s[i], 1'b0);
    check("run_done", done_s[i], 1'b1);
    check("run_busy", busy_s[i], 1'b0);
    check("run_in_ready", in_ready_s[i], 1'b0);
    check("run_word_count", wc_s[i], num_of(i));
    tick();
    tick();
    check("write_pulses", writes_seen[i] - n0, num_of(i));
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) in_data_s[i] = '0;
    reset_s = '1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) check_reset_values(i);
    reset_s = '0;
    tick();

    run_load(0, 0);
    run_load(0, 1);
    run_load(0, 2);

    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    in_valid_s[0] = 1'b1;
    for (int j = 0; j < 2; j++) begin
      in_data_s[0] = $urandom;
      tick();
    end
    in_valid_s[0] = 1'b0;
    reset_s[0] = 1'b1;
    tick();
    check_reset_values(0);
    reset_s[0] = 1'b0;
    tick();
    run_load(0, 2);

    run_load(1, 0);
    run_load(1, 2);

    in_valid_s[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_data_s[2] = $urandom;
      tick();
      check("idle_in_ready", in_ready_s[2], 1'b0);
      check("idle_busy", busy_s[2], 1'b0);
    end
    in_valid_s[2] = 1'b0;
    run_load(2, 0);
    in_valid_s[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_data_s[2] = $urandom;
      tick();
      check("run_hold_done", done_s[2], 1'b1);
      check("run_hold_wc", wc_s[2], 32'd3);
    end
    in_valid_s[2] = 1'b0;
    run_load(2, 2);

    tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
